nx_control_arbiter: RTL and testbench

- Shares the single `nx_control` host-command port between REQUESTERS independent sources, e.g. the host link and an on-chip debug/sequencer master.
- Round-robin grants single-beat `control_message_t` commands into `nx_control`'s inbound stream.
- Tracks which requester issued each response-producing command and routes each `control_response_t` back to that requester in order.
- Sits directly in front of `nx_control`.

---
 rtl/nx_control_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_nx_control_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nx_control_arbiter.sv
// nx_control_arbiter: shares the nx_control host-command port between
// REQUESTERS sources, tracks owners of response-producing commands and
// routes nx_control responses back to their issuers in order.
// Optional build macro NX_CTRL_ARB_PRIORITY_EN selects fixed priority
// (lowest index wins) instead of round-robin.
module nx_control_arbiter #(
    parameter int unsigned REQUESTERS      = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned MESSAGE_WIDTH  = 32
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [REQUESTERS*MESSAGE_WIDTH-1:0]   i_req_data,
    input  logic [REQUESTERS-1:0]                 i_req_valid,
    output logic [REQUESTERS-1:0]                 o_req_ready,
    output logic [REQUESTERS*MESSAGE_WIDTH-1:0]   o_rsp_data,
    output logic [REQUESTERS-1:0]                 o_rsp_valid,
    input  logic [REQUESTERS-1:0]                 i_rsp_ready,
    output logic [MESSAGE_WIDTH-1:0]              o_ctrl_data,
    output logic                                  o_ctrl_valid,
    input  logic                                  i_ctrl_ready,
    input  logic [MESSAGE_WIDTH-1:0]              i_ctrl_rsp_data,
    input  logic                                  i_ctrl_rsp_valid,
    output logic                                  o_ctrl_rsp_ready,
    output logic                                  o_error
);

    // control_message_t layout: command code in the top byte, payload below
    localparam int unsigned CMD_WIDTH  = 8;
    localparam int unsigned ID_WIDTH   = $clog2(REQUESTERS);
    localparam int unsigned PTR_WIDTH  = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_WIDTH  = PTR_WIDTH + 1;

    localparam logic [CMD_WIDTH-1:0] CONTROL_COMMAND_ACTIVE   = 8'h00;
    localparam logic [CMD_WIDTH-1:0] CONTROL_COMMAND_PARAM    = 8'h01;
    localparam logic [CMD_WIDTH-1:0] CONTROL_COMMAND_STATUS   = 8'h02;
    localparam logic [CMD_WIDTH-1:0] CONTROL_COMMAND_INTERVAL = 8'h03;
    localparam logic [CMD_WIDTH-1:0] CONTROL_COMMAND_RESET    = 8'h04;
    localparam logic [CMD_WIDTH-1:0] CONTROL_COMMAND_TRIGMASK = 8'h05;
    localparam logic [CMD_WIDTH-1:0] CONTROL_COMMAND_CYCLES   = 8'h06;

    // Only PARAM, STATUS and CYCLES make nx_control answer
    function automatic logic is_rsp_cmd(input logic [CMD_WIDTH-1:0] cmd);
        return (cmd == CONTROL_COMMAND_PARAM)  ||
               (cmd == CONTROL_COMMAND_STATUS) ||
               (cmd == CONTROL_COMMAND_CYCLES);
    endfunction

    logic [ID_WIDTH-1:0]      ptr_q;
    logic [MESSAGE_WIDTH-1:0] ctrl_data_q;
    logic                     ctrl_valid_q;
    logic                     error_q;

    logic [ID_WIDTH-1:0]      trk_q [MAX_OUTSTANDING];
    logic [PTR_WIDTH-1:0]     trk_wr_q;
    logic [PTR_WIDTH-1:0]     trk_rd_q;
    logic [CNT_WIDTH-1:0]     trk_cnt_q;
    logic                     trk_full;
    logic                     trk_empty;
    logic [ID_WIDTH-1:0]      trk_head;
    logic                     trk_push;
    logic                     trk_pop;

    logic                     stage_free;
    logic                     gnt_found;
    logic                     gnt_valid;
    logic [ID_WIDTH-1:0]      gnt_id;
    logic [MESSAGE_WIDTH-1:0] gnt_data;
    logic                     gnt_rsp;

    assign trk_full   = (trk_cnt_q == CNT_WIDTH'(MAX_OUTSTANDING));
    assign trk_empty  = (trk_cnt_q == '0);
    assign trk_head   = trk_q[trk_rd_q];
    assign stage_free = !ctrl_valid_q || i_ctrl_ready;

    // Grant search from the pointer; tracker-blocked requesters are skipped
    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_id    = '0;
        gnt_data  = '0;
        for (int unsigned k = 0; k < REQUESTERS; k++) begin
            idx = (32'(ptr_q) + k) % REQUESTERS;
            if (!gnt_found && i_req_valid[idx] &&
                !(trk_full && is_rsp_cmd(i_req_data[idx*MESSAGE_WIDTH + MESSAGE_WIDTH - CMD_WIDTH +: CMD_WIDTH]))) begin
                gnt_found = 1'b1;
                gnt_id    = ID_WIDTH'(idx);
                gnt_data  = i_req_data[idx*MESSAGE_WIDTH +: MESSAGE_WIDTH];
            end
        end
    end

    assign gnt_valid = !i_rst && stage_free && gnt_found;
    assign gnt_rsp   = is_rsp_cmd(gnt_data[MESSAGE_WIDTH-1 -: CMD_WIDTH]);
    assign trk_push  = gnt_valid && gnt_rsp;
    assign trk_pop   = !i_rst && i_ctrl_rsp_valid && o_ctrl_rsp_ready && !trk_empty;

    // One-hot ready to the granted requester
    always_comb begin
        o_req_ready = '0;
        for (int unsigned i = 0; i < REQUESTERS; i++) begin
            o_req_ready[i] = gnt_valid && (gnt_id == ID_WIDTH'(i));
        end
    end

    // Route the response to the owner at the tracker head
    always_comb begin
        o_rsp_valid = '0;
        o_rsp_data  = '0;
        for (int unsigned i = 0; i < REQUESTERS; i++) begin
            if (trk_head == ID_WIDTH'(i)) begin
                o_rsp_data[i*MESSAGE_WIDTH +: MESSAGE_WIDTH] = i_ctrl_rsp_data;
                o_rsp_valid[i] = i_ctrl_rsp_valid && !trk_empty && !i_rst;
            end
        end
        o_ctrl_rsp_ready = trk_empty ? 1'b1 : i_rsp_ready[trk_head];
    end

    // Command issue stage: load on grant, clear once nx_control takes it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ctrl_valid_q <= 1'b0;
            ctrl_data_q  <= '0;
        end else if (gnt_valid) begin
            ctrl_valid_q <= 1'b1;
            ctrl_data_q  <= gnt_data;
        end else if (i_ctrl_ready) begin
            ctrl_valid_q <= 1'b0;
        end
    end

    // Arbitration pointer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else begin
`ifdef NX_CTRL_ARB_PRIORITY_EN
            ptr_q <= '0;
`else
            if (gnt_valid) begin
                ptr_q <= (gnt_id == ID_WIDTH'(REQUESTERS - 1)) ? '0 : gnt_id + ID_WIDTH'(1);
            end
`endif
        end
    end

    // Response-owner FIFO
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            trk_wr_q  <= '0;
            trk_rd_q  <= '0;
            trk_cnt_q <= '0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                trk_q[i] <= '0;
            end
        end else begin
            if (trk_push) begin
                trk_q[trk_wr_q] <= gnt_id;
                trk_wr_q        <= trk_wr_q + PTR_WIDTH'(1);
            end
            if (trk_pop) begin
                trk_rd_q <= trk_rd_q + PTR_WIDTH'(1);
            end
            if (trk_push && !trk_pop) begin
                trk_cnt_q <= trk_cnt_q + CNT_WIDTH'(1);
            end else if (!trk_push && trk_pop) begin
                trk_cnt_q <= trk_cnt_q - CNT_WIDTH'(1);
            end
        end
    end

    // Sticky orphan-response flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            error_q <= 1'b0;
        end else if (i_ctrl_rsp_valid && trk_empty) begin
            error_q <= 1'b1;
        end
    end

    assign o_ctrl_data  = ctrl_data_q;
    assign o_ctrl_valid = ctrl_valid_q;
    assign o_error      = error_q;

endmodule

// File: tb/tb_nx_control_arbiter.sv
// Bench for nx_control_arbiter: directed steps with a reference model and
// scoreboard queues for issued commands and response owners.
module tb_nx_control_arbiter;

    localparam int unsigned R    = 2;
    localparam int unsigned MAXO = 4;
    localparam int unsigned MW   = 32;

    localparam logic [7:0] C_ACTIVE   = 8'h00;
    localparam logic [7:0] C_PARAM    = 8'h01;
    localparam logic [7:0] C_STATUS   = 8'h02;
    localparam logic [7:0] C_INTERVAL = 8'h03;
    localparam logic [7:0] C_CYCLES   = 8'h06;

    logic              clk = 1'b0;
    logic              rst;
    logic [R*MW-1:0]   req_data;
    logic [R-1:0]      req_valid;
    logic [R-1:0]      req_ready;
    logic [R*MW-1:0]   rsp_data;
    logic [R-1:0]      rsp_valid;
    logic [R-1:0]      rsp_ready;
    logic [MW-1:0]     ctrl_data;
    logic              ctrl_valid;
    logic              ctrl_ready;
    logic [MW-1:0]     ctrl_rsp_data;
    logic              ctrl_rsp_valid;
    logic              ctrl_rsp_ready;
    logic              error;

    always #5 clk = ~clk;

    nx_control_arbiter #(.REQUESTERS(R), .MAX_OUTSTANDING(MAXO)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_req_data       (req_data),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .o_rsp_data       (rsp_data),
        .o_rsp_valid      (rsp_valid),
        .i_rsp_ready      (rsp_ready),
        .o_ctrl_data      (ctrl_data),
        .o_ctrl_valid     (ctrl_valid),
        .i_ctrl_ready     (ctrl_ready),
        .i_ctrl_rsp_data  (ctrl_rsp_data),
        .i_ctrl_rsp_valid (ctrl_rsp_valid),
        .o_ctrl_rsp_ready (ctrl_rsp_ready),
        .o_error          (error)
    );

    int          checks   = 0;
    int          failures = 0;

    // Reference model state
    int          m_ptr;
    bit          m_valid;
    bit          m_err;
    int          m_gnt;
    logic [MW-1:0] exp_cmd_q[$];
    int          owner_q[$];

    function automatic logic [MW-1:0] msg(input logic [7:0] c, input logic [23:0] p);
        return {c, p};
    endfunction

    function automatic bit rsp_cmd(input logic [MW-1:0] m);
        logic [7:0] c;
        c = m[MW-1 -: 8];
        return (c == C_PARAM) || (c == C_STATUS) || (c == C_CYCLES);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 0;
        m_err   = 0;
        exp_cmd_q.delete();
        owner_q.delete();
    endtask

    // One clock: compare DUT against the model before the edge, then advance the model
    task automatic cycle();
        logic [R-1:0]  exp_rdy;
        logic [R-1:0]  exp_v;
        logic [MW-1:0] d;
        int            start;
        int            idx;
        int            h;
        #1;
        m_gnt = -1;
        if (!rst) begin
            chk("ctrl_valid", 64'(ctrl_valid), 64'(m_valid));
            if (m_valid) chk("ctrl_data", 64'(ctrl_data), 64'(exp_cmd_q[0]));
            if (!m_valid || ctrl_ready) begin
`ifdef NX_CTRL_ARB_PRIORITY_EN
                start = 0;
`else
                start = m_ptr;
`endif
                for (int k = 0; k < R; k++) begin
                    idx = (start + k) % R;
                    d   = req_data[idx*MW +: MW];
                    if (m_gnt < 0 && req_valid[idx] && !(rsp_cmd(d) && owner_q.size() == MAXO))
                        m_gnt = idx;
                end
            end
            exp_rdy = '0;
            if (m_gnt >= 0) exp_rdy[m_gnt] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            if (ctrl_rsp_valid) begin
                if (owner_q.size() == 0) begin
                    chk("orphan_rsp_ready", 64'(ctrl_rsp_ready), 64'(1));
                    chk("orphan_rsp_valid", 64'(rsp_valid), 64'(0));
                end else begin
                    h = owner_q[0];
                    exp_v = '0;
                    exp_v[h] = 1'b1;
                    chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
                    chk("rsp_data", 64'(rsp_data[h*MW +: MW]), 64'(ctrl_rsp_data));
                    chk("ctrl_rsp_ready", 64'(ctrl_rsp_ready), 64'(rsp_ready[h]));
                end
            end else begin
                chk("rsp_valid_idle", 64'(rsp_valid), 64'(0));
            end
            chk("error", 64'(error), 64'(m_err));
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_valid && ctrl_ready) begin
                void'(exp_cmd_q.pop_front());
                m_valid = 0;
            end
            if (ctrl_rsp_valid) begin
                if (owner_q.size() == 0) m_err = 1;
                else if (rsp_ready[owner_q[0]]) void'(owner_q.pop_front());
            end
            if (m_gnt >= 0) begin
                d = req_data[m_gnt*MW +: MW];
                exp_cmd_q.push_back(d);
                m_valid = 1;
                if (rsp_cmd(d)) owner_q.push_back(m_gnt);
`ifdef NX_CTRL_ARB_PRIORITY_EN
                m_ptr = 0;
`else
                m_ptr = (m_gnt + 1) % R;
`endif
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bit p_done;
        bit c_done;
        rst            = 1'b1;
        req_data       = '0;
        req_valid      = '0;
        rsp_ready      = '1;
        ctrl_ready     = 1'b1;
        ctrl_rsp_data  = '0;
        ctrl_rsp_valid = 1'b0;
        model_reset();
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("rst_ctrl_valid", 64'(ctrl_valid), 64'(0));
        chk("rst_ctrl_data", 64'(ctrl_data), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_error", 64'(error), 64'(0));

        // Single PARAM from requester 0, answered with 3
        req_data[0 +: MW] = msg(C_PARAM, 24'h000001);
        req_valid = 2'b01;
        cycle();
        req_valid = 2'b00;
        #1 chk("param_issue_valid", 64'(ctrl_valid), 64'(1));
        chk("param_issue_data", 64'(ctrl_data), 64'(msg(C_PARAM, 24'h000001)));
        cycle();
        ctrl_rsp_valid = 1'b1;
        ctrl_rsp_data  = 32'd3;
        #1 chk("param_rsp_valid", 64'(rsp_valid), 64'(2'b01));
        chk("param_rsp_data0", 64'(rsp_data[0 +: MW]), 64'(3));
        cycle();
        ctrl_rsp_valid = 1'b0;

        // Both requesters hold ACTIVE: alternating grants, one per cycle
        req_data[0 +: MW]  = msg(C_ACTIVE, 24'h0000A0);
        req_data[MW +: MW] = msg(C_ACTIVE, 24'h0000A1);
        req_valid = 2'b11;
        repeat (6) cycle();
        req_valid = 2'b00;
        cycle();

        // Fill the tracker from requester 1, then a blocked CYCLES beside an INTERVAL
        req_data[MW +: MW] = msg(C_STATUS, 24'h000010);
        req_valid = 2'b10;
        repeat (4) cycle();
        req_data[MW +: MW] = msg(C_CYCLES, 24'h000020);
        req_data[0 +: MW]  = msg(C_INTERVAL, 24'd10);
        req_valid = 2'b11;
        #1 chk("full_skip_ready", 64'(req_ready), 64'(2'b01));
        cycle();
        req_valid = 2'b10;
        cycle();
        ctrl_rsp_valid = 1'b1;
        ctrl_rsp_data  = 32'h100;
        cycle();
        ctrl_rsp_valid = 1'b0;
        #1 chk("unblocked_ready", 64'(req_ready), 64'(2'b10));
        cycle();
        req_valid = 2'b00;
        ctrl_rsp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ctrl_rsp_data = 32'h200 + 32'(i);
            cycle();
        end
        ctrl_rsp_valid = 1'b0;
        cycle();

        // Downstream stall with a staged command
        ctrl_ready = 1'b0;
        req_data[0 +: MW] = msg(C_ACTIVE, 24'h000005);
        req_valid = 2'b01;
        cycle();
        req_data[MW +: MW] = msg(C_INTERVAL, 24'd20);
        req_valid = 2'b10;
        repeat (5) cycle();
        ctrl_ready = 1'b1;
        #1 chk("stall_release_ready", 64'(req_ready), 64'(2'b10));
        cycle();
        req_valid = 2'b00;
        cycle();

        // Interleaved PARAM/CYCLES/STATUS
        req_data[0 +: MW]  = msg(C_PARAM, 24'h000002);
        req_data[MW +: MW] = msg(C_CYCLES, 24'h000030);
        req_valid = 2'b11;
        p_done = 0;
        c_done = 0;
        for (int n = 0; n < 8 && req_valid != 2'b00; n++) begin
            cycle();
            if (m_gnt == 1) req_valid[1] = 1'b0;
            if (m_gnt == 0) begin
                if (!p_done) begin
                    p_done = 1;
                    req_data[0 +: MW] = msg(C_STATUS, 24'h000040);
                end else begin
                    c_done = 1;
                    req_valid[0] = 1'b0;
                end
            end
        end
        chk("interleave_done", 64'(req_valid), 64'(0));
        cycle();
        rsp_ready = 2'b01;
        ctrl_rsp_valid = 1'b1;
        ctrl_rsp_data  = 32'h300;
        cycle();
        ctrl_rsp_data  = 32'h301;
        repeat (3) cycle();
        rsp_ready = 2'b11;
        cycle();
        ctrl_rsp_data  = 32'h302;
        cycle();
        ctrl_rsp_valid = 1'b0;
        cycle();

        // Orphan response sets the sticky error until reset
        ctrl_rsp_valid = 1'b1;
        ctrl_rsp_data  = 32'hDEAD;
        #1 chk("orphan_ready_direct", 64'(ctrl_rsp_ready), 64'(1));
        cycle();
        ctrl_rsp_valid = 1'b0;
        repeat (3) cycle();
        #1 chk("orphan_error_sticky", 64'(error), 64'(1));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1 chk("error_cleared", 64'(error), 64'(0));
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
